// File: rtl/uninasoc_pkg.sv
// Shared PLIC sizing, gateway state encoding and platform interrupt line IDs.
package uninasoc_pkg;

  localparam int PLIC_NUM_SOURCES = 32;
  localparam int PLIC_PRIO_WIDTH  = 3;

  // Platform interrupt lines; each value indexes irq_src_i of the PLIC.
  localparam int PLIC_RESERVED_INTERRUPT = 0;
  localparam int PLIC_GPIO_INTERRUPT     = 1;
  localparam int PLIC_TIM0_INTERRUPT     = 2;
  localparam int PLIC_TIM1_INTERRUPT     = 3;
  localparam int PLIC_UART_INTERRUPT     = 4;

  // Core-side line driven by irq_o (machine external interrupt).
  localparam int CORE_EXT_INTERRUPT = 11;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/uninasoc_irq_gateway.sv
// One interrupt gateway: input synchroniser, edge detector, saturating
// pending counter and the IDLE/PENDING/CLAIMED state machine.
module uninasoc_irq_gateway
  import uninasoc_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   MAX_PENDING = 3,
  parameter logic EDGE_TRIG   = 1'b0
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic irq_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   irq_sync;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q, cnt_dec, cnt_d;
  gw_state_e              state_q, state_d;

  assign irq_sync = sync_q[SYNC_STAGES-1];
  assign rise     = irq_sync & ~prev_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= GW_IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q  <= irq_sync;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Claim frees one slot before a coincident edge is counted, so an edge
  // arriving with the claim is not lost at saturation.
  always_comb begin
    cnt_dec = cnt_q;
    if (EDGE_TRIG && claim_i && (state_q == GW_PENDING) && (cnt_q != '0)) begin
      cnt_dec = cnt_q - CNT_ONE;
    end
    cnt_d = cnt_dec;
    if (EDGE_TRIG && rise && (cnt_dec < CNT_MAX)) begin
      cnt_d = cnt_dec + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GW_IDLE: begin
        if (EDGE_TRIG ? (cnt_d != '0) : irq_sync) state_d = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_i) state_d = GW_CLAIMED;
      end
      GW_CLAIMED: begin
        if (complete_i) state_d = (EDGE_TRIG && (cnt_d != '0)) ? GW_PENDING : GW_IDLE;
      end
      default: state_d = GW_IDLE;
    endcase
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/uninasoc_plic_lite.sv
// Single-hart PLIC: per-source gateways feeding a registered highest-priority
// arbiter with claim/complete handshake.
module uninasoc_plic_lite
  import uninasoc_pkg::*;
#(
  parameter int                    NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int                    PRIO_WIDTH  = PLIC_PRIO_WIDTH,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    MAX_PENDING = 3,
  parameter logic [NUM_SOURCES-1:0] EDGE_MODE  = '0
) (
  input  logic                              clock_i,
  input  logic                              reset_ni,
  input  logic [NUM_SOURCES-1:0]            irq_src_i,
  input  logic [NUM_SOURCES-1:0]            enable_i,
  input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]             threshold_i,
  input  logic                              claim_req_i,
  output logic                              claim_valid_o,
  output logic [$clog2(NUM_SOURCES)-1:0]    claim_id_o,
  input  logic                              complete_req_i,
  input  logic [$clog2(NUM_SOURCES)-1:0]    complete_id_i,
  output logic                              irq_o
);

  localparam int ID_W = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:1] claim_vec;
  logic [NUM_SOURCES-1:1] complete_vec;
  logic                   claim_grant;
  logic                   unused_src0;

  logic [ID_W-1:0]       best_id_p0;
  logic [PRIO_WIDTH-1:0] best_prio_p0;
  logic                  any_p0;

  logic [ID_W-1:0] best_id_p1;
  logic            irq_p1;
  logic            claim_valid_p1;
  logic [ID_W-1:0] claim_id_p1;

  // Line 0 is reserved and never raises an interrupt.
  assign pending[0]  = 1'b0;
  assign unused_src0 = irq_src_i[0] ^ enable_i[0] ^ (^prio_i[PRIO_WIDTH-1:0]);

  // A stale best ID (already claimed since it was registered) is not granted.
  assign claim_grant = claim_req_i & irq_p1 & pending[best_id_p1];

  for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_gw
    assign claim_vec[i]    = claim_grant & (best_id_p1 == ID_W'(i));
    assign complete_vec[i] = complete_req_i & (complete_id_i == ID_W'(i));

    uninasoc_irq_gateway #(
      .SYNC_STAGES (SYNC_STAGES),
      .MAX_PENDING (MAX_PENDING),
      .EDGE_TRIG   (EDGE_MODE[i])
    ) u_gw (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .irq_i      (irq_src_i[i]),
      .claim_i    (claim_vec[i]),
      .complete_i (complete_vec[i]),
      .pending_o  (pending[i])
    );
  end

  // Stage p0: eligibility and priority search, ties resolved to the lowest ID.
  always_comb begin
    best_id_p0   = '0;
    best_prio_p0 = '0;
    any_p0       = 1'b0;
    for (int i = 1; i < NUM_SOURCES; i++) begin
      if (pending[i] && enable_i[i]
          && (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > threshold_i)
          && (prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > best_prio_p0)) begin
        best_prio_p0 = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
        best_id_p0   = ID_W'(i);
        any_p0       = 1'b1;
      end
    end
  end

  // Stage p1: registered arbiter result and claim response.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      best_id_p1     <= '0;
      irq_p1         <= 1'b0;
      claim_valid_p1 <= 1'b0;
      claim_id_p1    <= '0;
    end else begin
      best_id_p1     <= best_id_p0;
      irq_p1         <= any_p0;
      claim_valid_p1 <= claim_req_i;
      if (claim_req_i) begin
        claim_id_p1 <= claim_grant ? best_id_p1 : '0;
      end
    end
  end

  assign irq_o         = irq_p1;
  assign claim_valid_o = claim_valid_p1;
  assign claim_id_o    = claim_id_p1;

endmodule

// File: tb/tb_uninasoc_plic_lite.sv
// Directed bench for uninasoc_plic_lite: latency, priority order, edge
// counting, threshold/enable gating, claim/complete corner cases and reset.
module tb_uninasoc_plic_lite;

  localparam int NS = 32;
  localparam int PW = 3;

  logic           clock_i = 1'b0;
  logic           reset_ni;
  logic [NS-1:0]  irq_src_i;
  logic [NS-1:0]  enable_i;
  logic [NS*PW-1:0] prio_i;
  logic [PW-1:0]  threshold_i;
  logic           claim_req_i;
  logic           claim_valid_o;
  logic [4:0]     claim_id_o;
  logic           complete_req_i;
  logic [4:0]     complete_id_i;
  logic           irq_o;

  int total = 0;
  int bad   = 0;

  uninasoc_plic_lite #(
    .NUM_SOURCES (NS),
    .PRIO_WIDTH  (PW),
    .SYNC_STAGES (2),
    .MAX_PENDING (3),
    .EDGE_MODE   (32'h0000_0004)
  ) dut (
    .clock_i        (clock_i),
    .reset_ni       (reset_ni),
    .irq_src_i      (irq_src_i),
    .enable_i       (enable_i),
    .prio_i         (prio_i),
    .threshold_i    (threshold_i),
    .claim_req_i    (claim_req_i),
    .claim_valid_o  (claim_valid_o),
    .claim_id_o     (claim_id_o),
    .complete_req_i (complete_req_i),
    .complete_id_i  (complete_id_i),
    .irq_o          (irq_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic set_prio(input int src, input int p);
    prio_i[src*PW +: PW] = p[PW-1:0];
  endtask

  task automatic do_claim(input string tag, input logic [4:0] exp);
    claim_req_i = 1'b1;
    step(1);
    chk({tag, "_valid"}, {31'd0, claim_valid_o}, 32'd1);
    chk({tag, "_id"}, {27'd0, claim_id_o}, {27'd0, exp});
    claim_req_i = 1'b0;
    step(1);
    chk({tag, "_pulse"}, {31'd0, claim_valid_o}, 32'd0);
  endtask

  task automatic do_complete(input logic [4:0] id);
    complete_req_i = 1'b1;
    complete_id_i  = id;
    step(1);
    complete_req_i = 1'b0;
  endtask

  initial begin
    reset_ni       = 1'b0;
    irq_src_i      = '0;
    enable_i       = '1;
    prio_i         = '0;
    threshold_i    = '0;
    claim_req_i    = 1'b0;
    complete_req_i = 1'b0;
    complete_id_i  = '0;
    #3;
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_cv", {31'd0, claim_valid_o}, 32'd0);
    chk("rst_cid", {27'd0, claim_id_o}, 32'd0);
    #9 reset_ni = 1'b1;
    step(1);

    // Level source 4: latency, claim, completion with line low.
    set_prio(4, 2);
    irq_src_i[4] = 1'b1;
    step(3);
    chk("lvl_lat3", {31'd0, irq_o}, 32'd0);
    step(1);
    chk("lvl_lat4", {31'd0, irq_o}, 32'd1);
    do_claim("lvl_claim", 5'd4);
    chk("lvl_irq_drop", {31'd0, irq_o}, 32'd0);
    step(2);
    chk("lvl_id_hold", {27'd0, claim_id_o}, 32'd4);
    irq_src_i[4] = 1'b0;
    step(3);
    do_complete(5'd4);
    step(6);
    chk("lvl_no_reassert", {31'd0, irq_o}, 32'd0);
    do_claim("lvl_empty", 5'd0);

    // Priority order: 1 (prio 7) then ties 2, 3 (prio 5) by lowest ID.
    set_prio(1, 7);
    set_prio(2, 5);
    set_prio(3, 5);
    irq_src_i[3:1] = 3'b111;
    step(5);
    chk("prio_irq", {31'd0, irq_o}, 32'd1);
    do_claim("prio_c1", 5'd1);
    do_claim("prio_c2", 5'd2);
    do_claim("prio_c3", 5'd3);
    do_claim("prio_c4", 5'd0);
    irq_src_i[3:1] = 3'b000;
    step(3);
    do_complete(5'd1);
    do_complete(5'd2);
    do_complete(5'd3);
    step(4);
    chk("prio_idle", {31'd0, irq_o}, 32'd0);

    // Edge source 2: five pulses saturate the counter at three.
    for (int p = 0; p < 5; p++) begin
      irq_src_i[2] = 1'b1;
      step(2);
      irq_src_i[2] = 1'b0;
      step(2);
    end
    step(3);
    chk("edge_irq", {31'd0, irq_o}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      do_claim($sformatf("edge_c%0d", c), 5'd2);
      chk($sformatf("edge_drop%0d", c), {31'd0, irq_o}, 32'd0);
      do_complete(5'd2);
      step(2);
    end
    chk("edge_empty_irq", {31'd0, irq_o}, 32'd0);
    do_claim("edge_c3", 5'd0);

    // Threshold: priority 1 needs threshold 0.
    set_prio(3, 1);
    threshold_i = 3'd1;
    irq_src_i[3] = 1'b1;
    step(6);
    chk("thr_block", {31'd0, irq_o}, 32'd0);
    threshold_i = 3'd0;
    step(1);
    chk("thr_open", {31'd0, irq_o}, 32'd1);
    do_claim("thr_claim", 5'd3);
    irq_src_i[3] = 1'b0;
    step(3);
    do_complete(5'd3);
    step(3);

    // Disabled pending source becomes eligible on enable.
    set_prio(5, 4);
    enable_i[5] = 1'b0;
    irq_src_i[5] = 1'b1;
    step(6);
    chk("dis_block", {31'd0, irq_o}, 32'd0);
    enable_i[5] = 1'b1;
    step(1);
    chk("dis_enable", {31'd0, irq_o}, 32'd1);
    do_claim("dis_claim", 5'd5);
    irq_src_i[5] = 1'b0;
    step(3);
    do_complete(5'd5);
    step(3);
    chk("dis_idle", {31'd0, irq_o}, 32'd0);

    // Claim and complete of the same ID in one cycle: completion ignored.
    set_prio(2, 5);
    irq_src_i[2] = 1'b1;
    step(5);
    chk("same_irq", {31'd0, irq_o}, 32'd1);
    claim_req_i    = 1'b1;
    complete_req_i = 1'b1;
    complete_id_i  = 5'd2;
    step(1);
    chk("same_id", {27'd0, claim_id_o}, 32'd2);
    claim_req_i    = 1'b0;
    complete_req_i = 1'b0;
    step(2);
    chk("same_irq_low", {31'd0, irq_o}, 32'd0);
    do_complete(5'd5);
    step(3);
    chk("unclaimed_cmp", {31'd0, irq_o}, 32'd0);
    irq_src_i[2] = 1'b0;
    step(3);
    irq_src_i[2] = 1'b1;
    step(4);
    chk("claimed_edge_hold", {31'd0, irq_o}, 32'd0);
    do_complete(5'd2);
    step(1);
    chk("claimed_cmp_repend", {31'd0, irq_o}, 32'd1);
    do_claim("same_reclaim", 5'd2);
    irq_src_i[2] = 1'b0;
    step(3);
    do_complete(5'd2);
    step(3);
    chk("same_idle", {31'd0, irq_o}, 32'd0);

    // Reset while source 4 is being claimed.
    set_prio(4, 2);
    irq_src_i[4] = 1'b1;
    step(5);
    chk("rc_irq", {31'd0, irq_o}, 32'd1);
    claim_req_i = 1'b1;
    step(1);
    claim_req_i = 1'b0;
    chk("rc_cv", {31'd0, claim_valid_o}, 32'd1);
    chk("rc_cid", {27'd0, claim_id_o}, 32'd4);
    reset_ni = 1'b0;
    #1;
    chk("rc_rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rc_rst_cv", {31'd0, claim_valid_o}, 32'd0);
    chk("rc_rst_cid", {27'd0, claim_id_o}, 32'd0);
    #1 reset_ni = 1'b1;
    step(3);
    chk("rc_lat3", {31'd0, irq_o}, 32'd0);
    step(1);
    chk("rc_lat4", {31'd0, irq_o}, 32'd1);
    do_claim("rc_claim", 5'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
